// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the byte loader's state encoding.
// lane_sel maps a byte index to its 8-bit lane within the 128-bit block.
package aes_pkg;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_BYTES      = 16;
    localparam int AES_BYTE_IDX_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } loader_state_t;

    // With MSB_FIRST, byte 0 goes to lane 15 (blk_data[127:120]); 15-idx is ~idx for 4 bits.
    function automatic logic [AES_BYTE_IDX_W-1:0] lane_sel(
        input logic [AES_BYTE_IDX_W-1:0] idx,
        input logic                      msb_first
    );
        return msb_first ? ~idx : idx;
    endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Packs 16 serial bytes into one AES-128 state block and hands it downstream.
// valid/ready: a byte moves on in_valid&&in_ready, a block on blk_valid&&blk_ready, at the rising edge.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_byte,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   blk_valid,
    output logic [AES_BLOCK_W-1:0] blk_data,
    input  logic                   blk_ready,
    output logic                   len_err,
    output logic [CNT_W-1:0]       blk_count
);

    loader_state_t             state;
    loader_state_t             state_next;
    logic [AES_BYTE_IDX_W-1:0] cnt;
    logic [AES_BYTE_IDX_W-1:0] lane;
    logic                      byte_xfer;
    logic                      blk_xfer;
    logic                      last_byte;
    logic                      early_last;

    assign byte_xfer  = in_valid && in_ready;
    assign blk_xfer   = blk_valid && blk_ready;
    assign last_byte  = (cnt == AES_BYTE_IDX_W'(AES_BYTES - 1));
    assign early_last = in_last && !last_byte;
    assign lane       = lane_sel(cnt, MSB_FIRST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (byte_xfer && last_byte) state_next = HOLD;
                HOLD:    if (blk_xfer) state_next = COLLECT;
                default: state_next = COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready  = !reset && (state == COLLECT);
        blk_valid = (state == HOLD);
    end

    // The byte carrying an early in_last is dropped, not written into the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            blk_data  <= '0;
            len_err   <= 1'b0;
            blk_count <= '0;
        end else begin
            len_err <= 1'b0;
            if (blk_xfer) begin
                blk_count <= blk_count + CNT_W'(1);
            end
            if (flush) begin
                cnt <= '0;
            end else if (byte_xfer) begin
                len_err <= (in_last != last_byte);
                if (early_last) begin
                    cnt <= '0;
                end else begin
                    blk_data[{lane, 3'b000} +: 8] <= in_byte;
                    cnt                           <= cnt + AES_BYTE_IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: MSB-first/16-bit counter build alongside
// an LSB-first/4-bit counter build sharing the same stimulus.
module tb_aes_block_loader;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         flush;
    logic         blk_ready;

    logic         in_ready;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         len_err;
    logic [15:0]  blk_count;

    logic         b_in_ready;
    logic         b_blk_valid;
    logic [127:0] b_blk_data;
    logic         b_len_err;
    logic [3:0]   b_blk_count;

    int checks = 0;
    int errors = 0;

    aes_block_loader #(.MSB_FIRST(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_last(in_last), .in_ready(in_ready), .flush(flush),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
        .len_err(len_err), .blk_count(blk_count)
    );

    aes_block_loader #(.MSB_FIRST(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_last(in_last), .in_ready(b_in_ready), .flush(flush),
        .blk_valid(b_blk_valid), .blk_data(b_blk_data), .blk_ready(blk_ready),
        .len_err(b_len_err), .blk_count(b_blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One byte per cycle from start, stepping by step; in_last optionally on the final byte.
    task automatic send_bytes(input logic [7:0] start, input logic [7:0] step,
                              input int n, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_byte  = start + step * 8'(i);
            in_last  = last_on_final && (i == n - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
        flush = 1'b0; blk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'd0);
        check_eq("rst_blk_valid", 128'(blk_valid), 128'd0);
        check_eq("rst_blk_data", blk_data, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("post_rst_count", 128'(blk_count), 128'd0);

        // Basic block, both byte orders, one-cycle blk_valid.
        send_bytes(8'h00, 8'h11, 16, 1'b1);
        check_eq("b1_valid", 128'(blk_valid), 128'd1);
        check_eq("b1_in_ready", 128'(in_ready), 128'd0);
        check_eq("b1_len_err", 128'(len_err), 128'd0);
        check_eq("b1_data_msb", blk_data, 128'h00112233445566778899aabbccddeeff);
        check_eq("b1_data_lsb", b_blk_data, 128'hffeeddccbbaa99887766554433221100);
        @(posedge clk); #1;
        check_eq("b1_valid_drop", 128'(blk_valid), 128'd0);
        check_eq("b1_count", 128'(blk_count), 128'd1);
        check_eq("b1_count_b", 128'(b_blk_count), 128'd1);

        // Back-pressure: hold for 5 cycles with in_valid high.
        blk_ready = 1'b0;
        send_bytes(8'h20, 8'h01, 16, 1'b1);
        check_eq("b2_valid", 128'(blk_valid), 128'd1);
        in_valid = 1'b1; in_byte = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_eq("b2_hold_in_ready", 128'(in_ready), 128'd0);
            check_eq("b2_hold_valid", 128'(blk_valid), 128'd1);
            check_eq("b2_hold_data", blk_data, 128'h202122232425262728292a2b2c2d2e2f);
            check_eq("b2_hold_count", 128'(blk_count), 128'd1);
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("b2_valid_drop", 128'(blk_valid), 128'd0);
        check_eq("b2_count", 128'(blk_count), 128'd2);
        check_eq("b2_in_ready", 128'(in_ready), 128'd1);

        // Early in_last on byte 7 discards the partial block.
        send_bytes(8'ha0, 8'h01, 7, 1'b1);
        check_eq("b3_len_err", 128'(len_err), 128'd1);
        check_eq("b3_no_valid", 128'(blk_valid), 128'd0);
        @(posedge clk); #1;
        check_eq("b3_len_err_pulse", 128'(len_err), 128'd0);
        check_eq("b3_still_no_valid", 128'(blk_valid), 128'd0);
        send_bytes(8'h10, 8'h01, 16, 1'b1);
        check_eq("b3_valid", 128'(blk_valid), 128'd1);
        check_eq("b3_data_msb", blk_data, 128'h101112131415161718191a1b1c1d1e1f);
        check_eq("b3_data_lsb", b_blk_data, 128'h1f1e1d1c1b1a19181716151413121110);
        @(posedge clk); #1;
        check_eq("b3_count", 128'(blk_count), 128'd3);

        // Flush mid-block (with a byte presented), then flush in HOLD.
        send_bytes(8'h50, 8'h01, 9, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'hee; in_last = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_eq("f1_len_err", 128'(len_err), 128'd0);
        check_eq("f1_valid", 128'(blk_valid), 128'd0);
        blk_ready = 1'b0;
        send_bytes(8'h60, 8'h01, 16, 1'b1);
        check_eq("f2_valid", 128'(blk_valid), 128'd1);
        check_eq("f2_data", blk_data, 128'h606162636465666768696a6b6c6d6e6f);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("f2_valid_drop", 128'(blk_valid), 128'd0);
        check_eq("f2_in_ready", 128'(in_ready), 128'd1);
        check_eq("f2_count", 128'(blk_count), 128'd3);
        send_bytes(8'h70, 8'h01, 16, 1'b1);
        check_eq("f3_valid", 128'(blk_valid), 128'd1);
        check_eq("f3_data", blk_data, 128'h707172737475767778797a7b7c7d7e7f);
        check_eq("f3_count", 128'(blk_count), 128'd3);

        // Asynchronous reset while holding.
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_valid", 128'(blk_valid), 128'd0);
        check_eq("ar_data", blk_data, 128'd0);
        check_eq("ar_count", 128'(blk_count), 128'd0);
        check_eq("ar_count_b", 128'(b_blk_count), 128'd0);
        check_eq("ar_in_ready", 128'(in_ready), 128'd0);
        check_eq("ar_len_err", 128'(len_err), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        blk_ready = 1'b1;
        #1;

        // Missing in_last on byte 16: completes but flags len_err.
        send_bytes(8'h80, 8'h01, 16, 1'b0);
        check_eq("nl_valid", 128'(blk_valid), 128'd1);
        check_eq("nl_len_err", 128'(len_err), 128'd1);
        check_eq("nl_data", blk_data, 128'h808182838485868788898a8b8c8d8e8f);
        @(posedge clk); #1;
        check_eq("nl_len_err_pulse", 128'(len_err), 128'd0);
        check_eq("nl_count", 128'(blk_count), 128'd1);

        // Flush coinciding with a transfer: the transfer still counts.
        send_bytes(8'h90, 8'h01, 16, 1'b1);
        check_eq("ft_valid", 128'(blk_valid), 128'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("ft_valid_drop", 128'(blk_valid), 128'd0);
        check_eq("ft_count", 128'(blk_count), 128'd2);
        check_eq("ft_in_ready", 128'(in_ready), 128'd1);

        // 14 more transfers: the 4-bit counter passes 15 and wraps to 0.
        for (int k = 0; k < 14; k++) begin
            send_bytes(8'ha0, 8'h01, 16, 1'b1);
            @(posedge clk); #1;
            if (k == 12) check_eq("wrap_at_15", 128'(b_blk_count), 128'd15);
        end
        check_eq("wrap_b_count", 128'(b_blk_count), 128'd0);
        check_eq("wrap_count", 128'(blk_count), 128'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
Byte-serial front end of the AES-128 encryption path. It packs 16 input bytes into one 128-bit state block, then presents the block with a valid/ready handshake. The downstream 128-bit state capture register takes blk_data on blk_valid as its start strobe, and uses blk_ready to pace the loader. The block also flags framing errors, supports abort, and counts completed blocks.

Parameters:
MSB_FIRST, 1, 1: first byte received lands in blk_data[127:120] (FIPS-197 byte 0); 0: first byte lands in blk_data[7:0]
CNT_W, 16, width of the completed-block counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_byte is valid this cycle
in_byte  in  8  plaintext byte
in_last  in  1  marks the byte the source believes is the 16th of a block
in_ready  out  1  loader accepts a byte this cycle
flush  in  1  synchronous abort of any partial or held block
blk_valid  out  1  blk_data holds a complete block (start strobe to the capture register)
blk_data  out  128  assembled block
blk_ready  in  1  downstream consumes the block this cycle
len_err  out  1  one-cycle pulse on an in_last framing mismatch
blk_count  out  CNT_W  number of blocks handed off, wraps modulo 2^CNT_W

Behaviour:
- Reset values (asynchronous): state=COLLECT, byte index cnt=0, blk_data=0, blk_valid=0, len_err=0, blk_count=0. in_ready is forced 0 while reset is high.
- A byte transfer occurs when in_valid && in_ready at a clock edge. A block transfer occurs when blk_valid && blk_ready at a clock edge.
- COLLECT state:
  - in_ready=1 and blk_valid=0.
  - Each byte transfer writes in_byte into the lane selected by cnt and MSB_FIRST, then increments cnt (4 bits).
  - Other lanes hold their values. Lanes are not cleared between blocks; every lane is rewritten before the next hand-off.
- On the byte transfer where cnt==15: go to HOLD, set blk_valid=1 on the next cycle, and reset cnt to 0. Latency from the 16th byte edge to blk_valid high is 1 cycle.
- HOLD state:
  - in_ready=0.
  - blk_valid and blk_data stay stable until a block transfer occurs.
  - On the transfer: blk_valid=0 next cycle, state=COLLECT, blk_count+1 (wraps from all-ones to 0).
  - The earliest byte of the next block is accepted the cycle after the transfer. The block interval is therefore at least 17 cycles.
- in_last checking (byte transfers only):
  - in_last=1 with cnt!=15: the partial block is discarded, cnt=0, state stays COLLECT, and len_err pulses next cycle. The offending byte is dropped.
  - cnt==15 with in_last=0: the block completes normally and len_err pulses next cycle.
  - in_last=1 with cnt==15: normal completion, no error.
- flush (highest priority, synchronous):
  - Next cycle: cnt=0, state=COLLECT, blk_valid=0.
  - Any byte presented in the same cycle is dropped. No len_err is raised.
  - If flush coincides with a block transfer, the transfer stands and blk_count increments; only the held state is cleared.
- blk_ready in COLLECT is ignored.
- Reset asserted mid-block or mid-HOLD clears everything immediately. No partial block survives.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128
  - AES_BYTES=16
  - AES_BYTE_IDX_W=4
  - loader state encoding (COLLECT=1'b0, HOLD=1'b1)
- Lane-select logic is a small indexed write. No sub-module is natural; the block stays a single flat module with one registered-state process and one next-state process.

Test Plan:
- Reset then 16 bytes 00,11,22,…,ff at one per cycle, in_last on the last byte, blk_ready=1:
  - blk_valid high for exactly 1 cycle, 1 cycle after byte 16.
  - blk_data=00112233445566778899aabbccddeeff, blk_count=1.
- Same stream with MSB_FIRST=0 -> blk_data=ffeeddccbbaa99887766554433221100.
- Block held with blk_ready=0 for 5 cycles, in_valid kept high:
  - in_ready=0 and blk_data stable throughout.
  - After blk_ready=1: blk_count increments once, and in_ready returns the next cycle.
- in_last on byte 7 -> len_err pulses once, no blk_valid. The next 16 bytes 10..1f yield blk_data=101112…1f.
- flush after 9 bytes, then flush in HOLD -> no block is produced, blk_count is unchanged, and the following full block assembles correctly.
- Assert reset while in HOLD with blk_count=3 -> all outputs return to 0 asynchronously. Run 2^CNT_W transfers (CNT_W=4 build) -> blk_count wraps from 15 to 0.
